ws2812_multi_fader: RTL and testbench
=====================================

// Module: ws2812_multi_fader
// PURPOSE
//  Parametrised successor of the single-stream fancy fader. Keeps current/target levels for
//  LED_COUNT RGB LEDs (3 channels each) and fades every channel toward a random target once per frame.
//  Starts each frame on the WS2812 serialiser and supplies one colour byte per data_request.
//  Sits between the LFSR/random source and the ws2812 bit driver.
// PARAMETERS
//  LED_COUNT     8      number of LEDs in the chain (>=1); channel count N = 3*LED_COUNT
//  COLOR_WIDTH   8      bits per channel byte
//  RANDOM_WIDTH  16     width of random input (>= COLOR_WIDTH)
//  STEP          4      per-frame level step magnitude (1 .. 2**COLOR_WIDTH-1)
//  FRAME_DIV     65536  idle clocks between end of one frame's SEND and the next update (>=2)
//  DIM_SHIFT     0      new targets are random[COLOR_WIDTH-1:0] >> DIM_SHIFT (global brightness cap)
// PORTS
//  clk           in   1             system clock, all logic on posedge
//  rst           in   1             synchronous reset, active-high
//  random        in   RANDOM_WIDTH  free-running random word, sampled when a target reloads
//  data_request  in   1             one-cycle pulse from driver: present next byte
//  trigger       out  1             one-cycle pulse: driver starts a new frame
//  color_now     out  COLOR_WIDTH   byte currently presented to the driver
//  busy          out  1             high in UPDATE and SEND states
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high. Clears all current and target levels,
//  the frame timer and the byte index. Sets state=IDLE. Outputs: trigger=0, color_now=0, busy=0.
//  Asserting rst mid-UPDATE or mid-SEND aborts the frame. No partial byte or trigger follows.
//  State machine:
//   IDLE: timer counts up each cycle. At timer==FRAME_DIV-1, clear the timer and go to UPDATE.
//   UPDATE: visits channel i = 0..N-1, one channel per cycle (N cycles).
//    cur<tgt: cur = min(cur+STEP, tgt).
//    cur>tgt: cur = max(cur-STEP, tgt).
//    Compare in COLOR_WIDTH+1 bits; never overshoot, never wrap.
//    cur==tgt: tgt = random[COLOR_WIDTH-1:0] >> DIM_SHIFT. cur is unchanged this frame.
//    After channel N-1: trigger=1 for exactly 1 cycle, byte index=0, go to SEND.
//   SEND: each data_request: color_now <= cur[index], index++. Byte is valid the cycle after the pulse.
//    Order per LED is G,R,B, starting at LED0. Channel i maps to LED i/3, colour (G,R,B)[i%3].
//    After the N-th byte is latched, go to IDLE. The timer restarts from 0.
//    A slow driver therefore stretches the frame period; frames never overlap.
//  data_request outside SEND (IDLE/UPDATE, incl. the trigger cycle) is ignored; color_now holds.
//  color_now holds the last byte until the next accepted request.
//  busy = (state==UPDATE || state==SEND), registered.
//  The random input may change every cycle. Each reload uses the value present in that cycle.
//  Level storage: register array or inferred RAM, N x COLOR_WIDTH each for cur and tgt.
//  Reset must leave all levels 0; a RAM implementation must clear itself before the first UPDATE.
// TESTING (LED_COUNT=2, STEP=16, FRAME_DIV=8, COLOR_WIDTH=8, RANDOM_WIDTH=16 unless noted)
//  1 Reset then idle, no requests.
//    -> trigger=0, color_now=0, busy=0 during rst.
//    -> first trigger exactly 8+6 cycles after rst falls.
//    -> busy high from the UPDATE start until 6 bytes are requested.
//  2 random=16'h00A0, driver answers each trigger with 6 requests.
//    -> frame 1 bytes all 0x00; frame 2 all 0x10; frame k all 16*(k-1).
//    -> frame 11 and later all 0xA0 (plateau, no overshoot).
//  3 After reaching 0xA0, random=16'h0005.
//    -> sequence 0xA0 (reload frame), 0x90, ..., 0x10, then 0x05, then holds 0x05 (clamped).
//  4 data_request pulses in IDLE, in UPDATE, on the trigger cycle, and a 7th pulse after 6 bytes.
//    -> color_now unchanged for each.
//    -> byte index unaffected; the next frame still starts at LED0 G.
//  5 rst asserted for 1 cycle after 3 bytes of a frame at level 0x30.
//    -> no further bytes; next trigger after 8+6 cycles; frame bytes all 0x00.
//  6 DIM_SHIFT=2, STEP=255, random=16'h00FF.
//    -> levels settle at 0x3F, never above.

Source files
------------

// File: rtl/ws2812_multi_fader.sv
// Per-channel random fader for a chain of WS2812 LEDs: steps every channel toward its target
// once per frame, then streams the current levels (G,R,B per LED) to the serialiser on request.
module ws2812_multi_fader #(
  parameter int LED_COUNT    = 8,
  parameter int COLOR_WIDTH  = 8,
  parameter int RANDOM_WIDTH = 16,
  parameter int STEP         = 4,
  parameter int FRAME_DIV    = 65536,
  parameter int DIM_SHIFT    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [RANDOM_WIDTH-1:0] random_i,
  input  logic                    data_request_i,
  output logic                    trigger_o,
  output logic [COLOR_WIDTH-1:0]  color_now_o,
  output logic                    busy_o
);

  localparam int N    = 3 * LED_COUNT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int TMRW = $clog2(FRAME_DIV);

  localparam logic [IDXW-1:0]      LAST_IDX = IDXW'(N - 1);
  localparam logic [TMRW-1:0]      TMR_LAST = TMRW'(FRAME_DIV - 1);
  localparam logic [COLOR_WIDTH:0] STEP_W   = (COLOR_WIDTH + 1)'(STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SEND   = 2'd2
  } state_t;

  logic [COLOR_WIDTH-1:0] cur_q [N];
  logic [COLOR_WIDTH-1:0] tgt_q [N];
  state_t                 state_q;
  logic [TMRW-1:0]        timer_q;
  logic [IDXW-1:0]        idx_q;
  logic                   trigger_q;
  logic [COLOR_WIDTH-1:0] color_q;
  logic                   busy_q;

  logic [COLOR_WIDTH-1:0] cur_sel;
  logic [COLOR_WIDTH-1:0] tgt_sel;
  logic [COLOR_WIDTH:0]   up_sum;
  logic [COLOR_WIDTH:0]   down_floor;
  logic [COLOR_WIDTH-1:0] reload_lvl;
  logic [COLOR_WIDTH-1:0] cur_d;
  logic [COLOR_WIDTH-1:0] tgt_d;

  // One extra bit on the sums so a step near full scale clamps instead of wrapping.
  always_comb begin
    cur_sel    = cur_q[idx_q];
    tgt_sel    = tgt_q[idx_q];
    up_sum     = {1'b0, cur_sel} + STEP_W;
    down_floor = {1'b0, tgt_sel} + STEP_W;
    reload_lvl = random_i[COLOR_WIDTH-1:0] >> DIM_SHIFT;
    cur_d      = cur_sel;
    tgt_d      = tgt_sel;
    if (cur_sel < tgt_sel) begin
      cur_d = (up_sum > {1'b0, tgt_sel}) ? tgt_sel : up_sum[COLOR_WIDTH-1:0];
    end else if (cur_sel > tgt_sel) begin
      cur_d = ({1'b0, cur_sel} >= down_floor) ? (cur_sel - STEP_W[COLOR_WIDTH-1:0]) : tgt_sel;
    end else begin
      tgt_d = reload_lvl;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      trigger_q <= 1'b0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      trigger_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (timer_q == TMR_LAST) begin
            timer_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= UPDATE;
          end else begin
            timer_q <= timer_q + TMRW'(1);
          end
        end
        UPDATE: begin
          cur_q[idx_q] <= cur_d;
          tgt_q[idx_q] <= tgt_d;
          if (idx_q == LAST_IDX) begin
            idx_q     <= '0;
            trigger_q <= 1'b1;
            state_q   <= SEND;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        SEND: begin
          // A request coinciding with the trigger pulse belongs to no frame yet.
          if (data_request_i && !trigger_q) begin
            color_q <= cur_sel;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              timer_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + IDXW'(1);
            end
          end
        end
        default: begin
          idx_q   <= '0;
          timer_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign trigger_o   = trigger_q;
  assign color_now_o = color_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ws2812_multi_fader.sv
// Self-checking bench for ws2812_multi_fader: frame timing, fade table, ignored requests,
// mid-frame reset, randomized frames against a behavioural model, and a dimmed instance.
module tb_ws2812_multi_fader;

  localparam int NCH    = 6;
  localparam int STEP_T = 16;
  localparam int FDIV   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        sel;
  logic [15:0] rnd;
  logic        req0, req6, trig0, trig6, busy0, busy6;
  logic [7:0]  col0, col6;
  logic        trig_s, busy_s;
  logic [7:0]  col_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] got [NCH];
  int         mcur [NCH];
  int         mtgt [NCH];

  typedef struct {
    logic [15:0] rnd;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [24];

  always #5 clk = ~clk;

  assign req0   = req & ~sel;
  assign req6   = req & sel;
  assign trig_s = sel ? trig6 : trig0;
  assign busy_s = sel ? busy6 : busy0;
  assign col_s  = sel ? col6 : col0;

  ws2812_multi_fader #(
    .LED_COUNT(2), .COLOR_WIDTH(8), .RANDOM_WIDTH(16),
    .STEP(STEP_T), .FRAME_DIV(FDIV), .DIM_SHIFT(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .random_i(rnd), .data_request_i(req0),
    .trigger_o(trig0), .color_now_o(col0), .busy_o(busy0)
  );

  ws2812_multi_fader #(
    .LED_COUNT(2), .COLOR_WIDTH(8), .RANDOM_WIDTH(16),
    .STEP(255), .FRAME_DIV(FDIV), .DIM_SHIFT(2)
  ) dut_dim (
    .clk_i(clk), .rst_i(rst), .random_i(rnd), .data_request_i(req6),
    .trigger_o(trig6), .color_now_o(col6), .busy_o(busy6)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_trigger(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (trig_s === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL trigger_timeout: no trigger within 200 cycles");
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic read_bytes(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse_req();
      got[i] = col_s;
    end
  endtask

  task automatic get_frame(input bit gaps);
    bit ok;
    wait_trigger(ok);
    if (ok) read_bytes(NCH, gaps);
    else for (int i = 0; i < NCH; i++) got[i] = 8'hxx;
  endtask

  task automatic check_all(input string name, input int exp);
    for (int i = 0; i < NCH; i++) check($sformatf("%s_byte%0d", name, i), got[i], exp);
  endtask

  // Reset for one edge, check outputs while held, then time the first trigger after release.
  task automatic reset_and_time(input string name, input bit drive_rnd, input bit spur);
    int first;
    first = -1;
    rst = 1'b1;
    @(negedge clk);
    check({name, "_rst_trigger"}, trig_s, 0);
    check({name, "_rst_color"}, col_s, 0);
    check({name, "_rst_busy"}, busy_s, 0);
    rst = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (drive_rnd && c >= 8 && c <= 13) rnd = 16'(c - 7);
      else if (drive_rnd && c == 14) rnd = 16'h0000;
      if (spur && c == 3) req = 1'b1;
      if (spur && c == 4) begin
        req = 1'b0;
        check({name, "_idle_req_color"}, col_s, 0);
      end
      if (c == FDIV - 1) check({name, "_busy_before_update"}, busy_s, 0);
      if (c == FDIV) check({name, "_busy_at_update"}, busy_s, 1);
      if (trig_s === 1'b1) begin
        first = c;
        break;
      end
    end
    check({name, "_first_trigger_cycle"}, first, FDIV + NCH);
  endtask

  task automatic model_frame(input logic [15:0] r, input int step, input int dim);
    for (int ch = 0; ch < NCH; ch++) begin
      if (mcur[ch] < mtgt[ch]) mcur[ch] = (mcur[ch] + step > mtgt[ch]) ? mtgt[ch] : mcur[ch] + step;
      else if (mcur[ch] > mtgt[ch]) mcur[ch] = (mcur[ch] - step < mtgt[ch]) ? mtgt[ch] : mcur[ch] - step;
      else mtgt[ch] = (int'(r) % 256) >> dim;
    end
  endtask

  initial begin
    bit ok;
    logic [15:0] r;

    for (int k = 0; k < 12; k++) begin
      vecs[k].rnd = 16'h00A0;
      vecs[k].exp = (16 * k > 160) ? 8'hA0 : 8'(16 * k);
    end
    vecs[12].rnd = 16'h0005;
    vecs[12].exp = 8'hA0;
    for (int k = 13; k < 22; k++) begin
      vecs[k].rnd = 16'h0005;
      vecs[k].exp = 8'(8'h90 - 16 * (k - 13));
    end
    vecs[22].rnd = 16'h0005;  vecs[22].exp = 8'h05;
    vecs[23].rnd = 16'h0005;  vecs[23].exp = 8'h05;

    rst = 1'b1;
    req = 1'b0;
    sel = 1'b0;
    rnd = 16'h0000;
    @(negedge clk);

    // Reset timing; first UPDATE loads per-channel targets 1..6 from a per-cycle random word.
    reset_and_time("t1", 1'b1, 1'b0);
    read_bytes(NCH, 1'b0);
    check_all("t1_frame1", 0);
    check("t1_busy_after_6", busy_s, 0);

    // Ignored requests in IDLE, UPDATE, on the trigger cycle and after the last byte.
    pulse_req();
    check("t4_idle_req", col_s, 0);
    for (int c = 0; c < 100 && busy_s !== 1'b1; c++) @(negedge clk);
    pulse_req();
    check("t4_update_req", col_s, 0);
    wait_trigger(ok);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("t4_trigger_cycle_req", col_s, 0);
    read_bytes(NCH, 1'b0);
    for (int i = 0; i < NCH; i++) check($sformatf("t4_frame2_byte%0d", i), got[i], i + 1);
    pulse_req();
    check("t4_seventh_req", col_s, 6);
    get_frame(1'b0);
    for (int i = 0; i < NCH; i++) check($sformatf("t4_frame3_byte%0d", i), got[i], i + 1);
    get_frame(1'b0);
    check_all("t4_frame4", 0);

    // Reset after 3 bytes of a frame at 0x30.
    rnd = 16'h00A0;
    reset_and_time("t5pre", 1'b0, 1'b0);
    read_bytes(NCH, 1'b0);
    get_frame(1'b0);
    get_frame(1'b0);
    wait_trigger(ok);
    read_bytes(3, 1'b0);
    for (int i = 0; i < 3; i++) check($sformatf("t5_partial_byte%0d", i), got[i], 8'h30);
    reset_and_time("t5", 1'b0, 1'b1);
    read_bytes(NCH, 1'b0);
    check_all("t5_after_reset", 0);

    // Fade table: ramp to plateau, then ramp down and clamp.
    rnd = vecs[0].rnd;
    reset_and_time("t2", 1'b0, 1'b0);
    for (int v = 0; v < 24; v++) begin
      rnd = vecs[v].rnd;
      if (v == 0) read_bytes(NCH, 1'b0);
      else get_frame(1'b0);
      check_all($sformatf("t23_frame%0d", v + 1), int'(vecs[v].exp));
    end

    // Randomized frames against the behavioural model.
    for (int ch = 0; ch < NCH; ch++) begin
      mcur[ch] = 0;
      mtgt[ch] = 0;
    end
    r = 16'($urandom);
    rnd = r;
    reset_and_time("rnd", 1'b0, 1'b0);
    for (int f = 0; f < 40; f++) begin
      model_frame(r, STEP_T, 0);
      if (f == 0) read_bytes(NCH, 1'b1);
      else get_frame(1'b1);
      for (int i = 0; i < NCH; i++) check($sformatf("rnd_f%0d_byte%0d", f, i), got[i], mcur[i]);
      r = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      rnd = r;
    end

    // Dimmed instance: full-scale step, targets capped at 0xFF >> 2.
    sel = 1'b1;
    rnd = 16'h00FF;
    reset_and_time("t6", 1'b0, 1'b0);
    read_bytes(NCH, 1'b0);
    check_all("t6_frame1", 0);
    for (int f = 2; f <= 5; f++) begin
      get_frame(1'b0);
      check_all($sformatf("t6_frame%0d", f), 8'h3F);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
